// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller:
// opcodes, FSM states, mux select codes and the per-state control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_ADDI_EX   = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word; FETCH's PC/IR loads are gated by ready elsewhere.
    function automatic ctrl_t ctrl_of(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_BOFF;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RT;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/handshake in, mux and enable controls out.
interface multicycle_control_if;

    logic       start_i;
    logic [5:0] Op_i;
    logic       MemReady_i;

    logic       PCWrite_o;
    logic       PCWriteCond_o;
    logic [1:0] PCSource_o;
    logic       IorD_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       IRWrite_o;
    logic       MemtoReg_o;
    logic       RegDst_o;
    logic       RegWrite_o;
    logic       ALUSrcA_o;
    logic [1:0] ALUSrcB_o;
    logic [1:0] ALUOp_o;
    logic [3:0] State_o;
    logic       MemErr_o;
    logic       IllegalOp_o;

    modport master (
        input  start_i, Op_i, MemReady_i,
        output PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o,
        output MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o,
        output RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
        output ALUOp_o, State_o, MemErr_o, IllegalOp_o
    );

    modport slave (
        output start_i, Op_i, MemReady_i,
        input  PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o,
        input  MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o,
        input  RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
        input  ALUOp_o, State_o, MemErr_o, IllegalOp_o
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags the
// cycle on which the MAX_WAIT budget runs out without a ready.
module mem_wait_timer #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    logic [WAIT_W-1:0] cnt;

    assign timeout = active && !ready
                  && (cnt == WAIT_W'(MAX_WAIT - 1));

    // Any exit from the waiting state (ready or abort) restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!active || ready || timeout)
            cnt <= '0;
        else
            cnt <= cnt + WAIT_W'(1);
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS-subset datapath.
// Optional perf counters: define MULTICYCLE_CTRL_PERF_EN.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_control_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0]          InstrCnt_o,
    output logic [31:0]          CycleCnt_o
`endif
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   mem_err_q;
    logic   ill_q;
    logic   illegal_d;
    logic   timeout;
    logic   ready;
    logic   fetch_go;
    logic [5:0] op;

    assign ready = bus.MemReady_i;
    assign op    = bus.Op_i;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .active  (is_mem_state(state_q)),
        .ready   (ready),
        .timeout (timeout)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        unique case (state_q)
            S_IDLE:
                if (bus.start_i) state_d = S_FETCH;
            S_FETCH:
                if (ready)        state_d = S_DECODE;
                else if (timeout) state_d = S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    (op == OP_LW) || (op == OP_SW): state_d = S_MEM_ADDR;
                    (op == OP_RTYPE):               state_d = S_EXECUTE;
                    (op == OP_ADDI):                state_d = S_ADDI_EX;
                    (op == OP_BEQ):                 state_d = S_BRANCH;
                    (op == OP_J):                   state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:
                state_d = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:
                if (ready)        state_d = S_MEM_WB;
                else if (timeout) state_d = S_FETCH;
            S_MEM_WRITE:
                if (ready || timeout) state_d = S_FETCH;
            S_EXECUTE: state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            mem_err_q <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_of(state_d);
            mem_err_q <= timeout;
            ill_q     <= illegal_d;
        end
    end

    assign fetch_go = (state_q == S_FETCH) && ready;

    assign bus.PCWrite_o     = ctrl_q.pc_write || fetch_go;
    assign bus.IRWrite_o     = fetch_go;
    assign bus.PCWriteCond_o = ctrl_q.pc_write_cond;
    assign bus.PCSource_o    = ctrl_q.pc_source;
    assign bus.IorD_o        = ctrl_q.iord;
    assign bus.MemRead_o     = ctrl_q.mem_read;
    assign bus.MemWrite_o    = ctrl_q.mem_write;
    assign bus.MemtoReg_o    = ctrl_q.mem_to_reg;
    assign bus.RegDst_o      = ctrl_q.reg_dst;
    assign bus.RegWrite_o    = ctrl_q.reg_write;
    assign bus.ALUSrcA_o     = ctrl_q.alu_src_a;
    assign bus.ALUSrcB_o     = ctrl_q.alu_src_b;
    assign bus.ALUOp_o       = ctrl_q.alu_op;
    assign bus.State_o       = state_q;
    assign bus.MemErr_o      = mem_err_q;
    assign bus.IllegalOp_o   = ill_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;

    // Only completed instructions retire; aborts return to FETCH uncounted.
    assign retire = (state_d == S_FETCH)
                 && ((state_q == S_MEM_WB) || (state_q == S_R_WB)
                  || (state_q == S_ADDI_WB) || (state_q == S_BRANCH)
                  || (state_q == S_JUMP)
                  || ((state_q == S_MEM_WRITE) && ready));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            InstrCnt_o <= '0;
            CycleCnt_o <= '0;
        end else begin
            if (state_q != S_IDLE) CycleCnt_o <= CycleCnt_o + 32'd1;
            if (retire)            InstrCnt_o <= InstrCnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MAX_WAIT=4).
// Build with MULTICYCLE_CTRL_PERF_EN defined to also check the counters.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    multicycle_control_if bus ();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instr_cnt;
    logic [31:0] cycle_cnt;
`endif

    multicycle_control #(
        .MAX_WAIT (4),
        .WAIT_W   (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .InstrCnt_o (instr_cnt),
        .CycleCnt_o (cycle_cnt)
`endif
    );

    wire [21:0] all_out = {
        bus.PCWrite_o, bus.PCWriteCond_o, bus.PCSource_o, bus.IorD_o,
        bus.MemRead_o, bus.MemWrite_o, bus.IRWrite_o, bus.MemtoReg_o,
        bus.RegDst_o, bus.RegWrite_o, bus.ALUSrcA_o, bus.ALUSrcB_o,
        bus.ALUOp_o, bus.State_o, bus.MemErr_o, bus.IllegalOp_o
    };

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.Op_i = 6'd0;
        bus.MemReady_i = 1'b0;
        #2;
        total++;
        if (all_out !== 22'd0)
            $display("FAIL reset_outputs: got %h want 0", all_out);
        else passed++;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus.State_o !== 4'd0 || all_out !== 22'd0)
            $display("FAIL idle_hold: state=%0d out=%h want 0/0",
                     bus.State_o, all_out);
        else passed++;
    endtask

    task automatic test_lw;
        logic [3:0] exp [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        logic rw;
        bus.start_i = 1'b1;
        bus.MemReady_i = 1'b1;
        bus.Op_i = OP_LW;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.start_i = 1'b0;
            rw = (exp[i] == 4'd5);
            total++;
            if (bus.State_o !== exp[i] || bus.RegWrite_o !== rw
                || bus.MemtoReg_o !== rw)
                $display("FAIL lw_step%0d: state=%0d rw=%b m2r=%b want %0d/%b/%b",
                         i, bus.State_o, bus.RegWrite_o, bus.MemtoReg_o,
                         exp[i], rw, rw);
            else passed++;
        end
        total++;
        if (bus.IRWrite_o !== 1'b1 || bus.MemRead_o !== 1'b1
            || bus.ALUSrcB_o !== 2'b01)
            $display("FAIL fetch_ctrl: ir=%b mr=%b srcb=%b want 1/1/01",
                     bus.IRWrite_o, bus.MemRead_o, bus.ALUSrcB_o);
        else passed++;
    endtask

    task automatic test_rtype;
        bus.Op_i = OP_RTYPE;
        tick();
        tick();
        total++;
        if (bus.State_o !== 4'd7 || bus.ALUOp_o !== 2'b11
            || bus.ALUSrcA_o !== 1'b1 || bus.ALUSrcB_o !== 2'b00)
            $display("FAIL r_execute: st=%0d aluop=%b a=%b b=%b want 7/11/1/00",
                     bus.State_o, bus.ALUOp_o, bus.ALUSrcA_o, bus.ALUSrcB_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd8 || bus.RegWrite_o !== 1'b1
            || bus.RegDst_o !== 1'b1)
            $display("FAIL r_wb: st=%0d rw=%b rd=%b want 8/1/1",
                     bus.State_o, bus.RegWrite_o, bus.RegDst_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd1)
            $display("FAIL r_latency: st=%0d want 1", bus.State_o);
        else passed++;
    endtask

    task automatic test_fetch_wait;
        bus.MemReady_i = 1'b0;
        bus.Op_i = OP_J;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.State_o !== 4'd1 || bus.IRWrite_o !== 1'b0
                || bus.PCWrite_o !== 1'b0 || bus.MemRead_o !== 1'b1)
                $display("FAIL fetch_wait%0d: st=%0d ir=%b pc=%b want 1/0/0",
                         i, bus.State_o, bus.IRWrite_o, bus.PCWrite_o);
            else passed++;
            tick();
        end
        bus.MemReady_i = 1'b1;
        #1;
        total++;
        if (bus.State_o !== 4'd1 || bus.IRWrite_o !== 1'b1
            || bus.PCWrite_o !== 1'b1)
            $display("FAIL fetch_ready: st=%0d ir=%b pc=%b want 1/1/1",
                     bus.State_o, bus.IRWrite_o, bus.PCWrite_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd2 || bus.IRWrite_o !== 1'b0
            || bus.MemErr_o !== 1'b0)
            $display("FAIL fetch_to_decode: st=%0d ir=%b err=%b want 2/0/0",
                     bus.State_o, bus.IRWrite_o, bus.MemErr_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd12 || bus.PCWrite_o !== 1'b1
            || bus.PCSource_o !== 2'b10)
            $display("FAIL jump: st=%0d pcw=%b src=%b want 12/1/10",
                     bus.State_o, bus.PCWrite_o, bus.PCSource_o);
        else passed++;
        tick();
    endtask

    task automatic test_mem_timeout;
        bus.Op_i = OP_SW;
        tick();
        tick();
        total++;
        if (bus.State_o !== 4'd3 || bus.ALUSrcB_o !== 2'b10)
            $display("FAIL mem_addr: st=%0d srcb=%b want 3/10",
                     bus.State_o, bus.ALUSrcB_o);
        else passed++;
        bus.MemReady_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.State_o !== 4'd6 || bus.MemWrite_o !== 1'b1
                || bus.IorD_o !== 1'b1 || bus.MemErr_o !== 1'b0)
                $display("FAIL sw_wait%0d: st=%0d mw=%b iord=%b err=%b want 6/1/1/0",
                         i, bus.State_o, bus.MemWrite_o, bus.IorD_o,
                         bus.MemErr_o);
            else passed++;
            tick();
        end
        total++;
        if (bus.State_o !== 4'd1 || bus.MemErr_o !== 1'b1
            || bus.IRWrite_o !== 1'b0 || bus.PCWrite_o !== 1'b0)
            $display("FAIL timeout: st=%0d err=%b ir=%b pc=%b want 1/1/0/0",
                     bus.State_o, bus.MemErr_o, bus.IRWrite_o, bus.PCWrite_o);
        else passed++;
        bus.MemReady_i = 1'b1;
        tick();
        total++;
        if (bus.State_o !== 4'd2 || bus.MemErr_o !== 1'b0)
            $display("FAIL timeout_pulse: st=%0d err=%b want 2/0",
                     bus.State_o, bus.MemErr_o);
        else passed++;
        tick();
        bus.MemReady_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        bus.MemReady_i = 1'b1;
        #1;
        total++;
        if (bus.State_o !== 4'd6 || bus.MemWrite_o !== 1'b1)
            $display("FAIL sw_last_wait: st=%0d mw=%b want 6/1",
                     bus.State_o, bus.MemWrite_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd1 || bus.MemErr_o !== 1'b0)
            $display("FAIL ready_priority: st=%0d err=%b want 1/0",
                     bus.State_o, bus.MemErr_o);
        else passed++;
    endtask

    task automatic test_illegal;
        bus.Op_i = 6'b111111;
        tick();
        total++;
        if (bus.State_o !== 4'd2 || bus.IllegalOp_o !== 1'b0)
            $display("FAIL illegal_decode: st=%0d ill=%b want 2/0",
                     bus.State_o, bus.IllegalOp_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd1 || bus.IllegalOp_o !== 1'b1
            || bus.RegWrite_o !== 1'b0 || bus.MemWrite_o !== 1'b0
            || bus.PCWriteCond_o !== 1'b0)
            $display("FAIL illegal_pulse: st=%0d ill=%b rw=%b mw=%b want 1/1/0/0",
                     bus.State_o, bus.IllegalOp_o, bus.RegWrite_o,
                     bus.MemWrite_o);
        else passed++;
`ifdef MULTICYCLE_CTRL_PERF_EN
        total++;
        if (instr_cnt !== 32'd4)
            $display("FAIL illegal_instr_cnt: got %0d want 4", instr_cnt);
        else passed++;
`endif
        bus.Op_i = OP_BEQ;
        tick();
        total++;
        if (bus.State_o !== 4'd2 || bus.IllegalOp_o !== 1'b0)
            $display("FAIL illegal_once: st=%0d ill=%b want 2/0",
                     bus.State_o, bus.IllegalOp_o);
        else passed++;
    endtask

    task automatic test_branch;
        tick();
        total++;
        if (bus.State_o !== 4'd11 || bus.PCWriteCond_o !== 1'b1
            || bus.PCSource_o !== 2'b01 || bus.ALUOp_o !== 2'b01
            || bus.ALUSrcA_o !== 1'b1 || bus.PCWrite_o !== 1'b0)
            $display("FAIL branch: st=%0d pwc=%b src=%b op=%b want 11/1/01/01",
                     bus.State_o, bus.PCWriteCond_o, bus.PCSource_o,
                     bus.ALUOp_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd1)
            $display("FAIL branch_done: st=%0d want 1", bus.State_o);
        else passed++;
    endtask

    task automatic test_addi;
        bus.Op_i = OP_ADDI;
        tick();
        tick();
        total++;
        if (bus.State_o !== 4'd9 || bus.ALUSrcB_o !== 2'b10
            || bus.ALUSrcA_o !== 1'b1 || bus.ALUOp_o !== 2'b00)
            $display("FAIL addi_ex: st=%0d b=%b a=%b op=%b want 9/10/1/00",
                     bus.State_o, bus.ALUSrcB_o, bus.ALUSrcA_o, bus.ALUOp_o);
        else passed++;
        tick();
        total++;
        if (bus.State_o !== 4'd10 || bus.RegWrite_o !== 1'b1
            || bus.RegDst_o !== 1'b0 || bus.MemtoReg_o !== 1'b0)
            $display("FAIL addi_wb: st=%0d rw=%b rd=%b want 10/1/0",
                     bus.State_o, bus.RegWrite_o, bus.RegDst_o);
        else passed++;
        tick();
`ifdef MULTICYCLE_CTRL_PERF_EN
        total++;
        if (instr_cnt !== 32'd6)
            $display("FAIL instr_cnt: got %0d want 6", instr_cnt);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid;
        bus.Op_i = OP_LW;
        bus.MemReady_i = 1'b1;
        tick();
        tick();
        bus.MemReady_i = 1'b0;
        tick();
        total++;
        if (bus.State_o !== 4'd4 || bus.MemRead_o !== 1'b1)
            $display("FAIL mid_read: st=%0d mr=%b want 4/1",
                     bus.State_o, bus.MemRead_o);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (all_out !== 22'd0)
            $display("FAIL async_reset: got %h want 0", all_out);
        else passed++;
        tick();
        rst = 1'b0;
        bus.MemReady_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.State_o !== 4'd0 || bus.RegWrite_o !== 1'b0)
                $display("FAIL post_reset%0d: st=%0d rw=%b want 0/0",
                         i, bus.State_o, bus.RegWrite_o);
            else passed++;
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        total++;
        if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0)
            $display("FAIL perf_reset: instr=%0d cyc=%0d want 0/0",
                     instr_cnt, cycle_cnt);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_fetch_wait();
        test_mem_timeout();
        test_illegal();
        test_branch();
        test_addi();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d",
                 passed, total);
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath (R-type, addi, lw, sw, beq, j).
- Replaces single-cycle decode with a Moore FSM that steps the shared ALU, unified instruction/data memory and register file through fetch/decode/execute/memory/writeback.
- Handles variable-latency memory via ready handshake with timeout.
- Sits between instruction register opcode field and all datapath mux/enable controls.

Parameters:
- MAX_WAIT, 16, consecutive not-ready cycles tolerated in a memory state before abort (>=1)
- WAIT_W, 5, width of wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  leave IDLE and begin fetching
- Op_i  in  6  opcode from instruction register
- MemReady_i  in  1  memory completes current access this cycle
- PCWrite_o  out  1  unconditional PC load
- PCWriteCond_o  out  1  PC load if ALU zero
- PCSource_o  out  2  00 ALU result, 01 ALUOut reg, 10 jump target
- IorD_o  out  1  0 PC addresses memory, 1 ALUOut addresses memory
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  instruction register load
- MemtoReg_o  out  1  writeback source memory data register
- RegDst_o  out  1  1 rd, 0 rt
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  0 PC, 1 rs
- ALUSrcB_o  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUOp_o  out  2  00 add, 01 sub, 11 funct-decoded
- State_o  out  4  current state encoding (debug)
- MemErr_o  out  1  one-cycle pulse on memory timeout
- IllegalOp_o  out  1  one-cycle pulse on undecoded opcode

Behaviour:
- Reset: state IDLE; every output 0; wait counter 0. Reset mid-instruction aborts immediately, no further writes.
- Outputs are decoded from the state register only (Moore), except FETCH IRWrite_o/PCWrite_o, gated by MemReady_i.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, ADDI_EX=9, ADDI_WB=10, BRANCH=11, JUMP=12. Signals not listed for a state are 0.
- IDLE: start_i=1 -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady_i. MemReady_i=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by Op_i:
  - 100011/101011 -> MEM_ADDR
  - 000000 -> EXECUTE
  - 001000 -> ADDI_EX
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other -> FETCH, with IllegalOp_o=1 for the following cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEM_READ; sw -> MEM_WRITE. Op_i is held stable by the IR.
- MEM_READ: MemRead=1, IorD=1. Ready -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Ready -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=11 -> R_WB.
- R_WB: RegWrite=1, RegDst=1 -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- Memory handshake and timeout (memory states = FETCH, MEM_READ, MEM_WRITE):
  - Wait counter increments each cycle with MemReady_i=0 and clears on state change.
  - When counter reaches MAX_WAIT-1 with MemReady_i=0: MemErr_o pulses the next cycle, next state is FETCH, and no PC/IR/register write occurs.
  - MemReady_i=1 on the final wait cycle takes priority over the timeout.
- Latencies with zero-wait memory: R/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
- start_i is ignored outside IDLE. The FSM never returns to IDLE except via reset.

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_EN.
- Defined: adds outputs InstrCnt_o[31:0] and CycleCnt_o[31:0], both reset to 0.
  - CycleCnt_o increments every non-IDLE cycle.
  - InstrCnt_o increments on every transition into FETCH from a writeback, store, branch or jump state. Illegal-op and timeout aborts do not count.
  - Both counters wrap at 2^32.
- Undefined: ports and logic absent; otherwise identical behaviour.

Decomposition:
- Shared package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J), state encoding enum, ALUOp/ALUSrcB/PCSource encodings.
- One sub-module: mem_wait_timer (wait counter plus timeout compare, parameterised by MAX_WAIT/WAIT_W).

Test Plan:
- Reset mid-MEM_READ (state 4) -> all outputs 0 and State_o=0 asynchronously; no RegWrite afterwards until start_i.
- start_i=1, Op_i=100011, MemReady_i always 1 -> states 1,2,3,4,5,1; RegWrite_o=MemtoReg_o=1 only in state 5.
- Op_i=000000 -> ALUOp_o=11 in EXECUTE, RegWrite_o=RegDst_o=1 in R_WB, 4-cycle instruction.
- FETCH with MemReady_i low 3 cycles then high -> IRWrite_o/PCWrite_o low 3 cycles, high exactly 1 cycle, then DECODE.
- MAX_WAIT=4, MEM_WRITE with MemReady_i stuck 0 -> MemWrite_o high 4 cycles, MemErr_o single pulse, back to FETCH; ready on 4th cycle -> no error.
- Op_i=111111 in DECODE -> IllegalOp_o pulse 1 cycle, FETCH next, no writes; with MULTICYCLE_CTRL_PERF_EN, InstrCnt_o unchanged.
